// File: rtl/mod_exp_core.sv
// Montgomery modular exponentiation, RESULT = M^E mod N, behind a byte-wide register bus.
// Optional MODEXP_ERR_EN adds an err output that rejects even or trivial moduli.
module mod_exp_core #(
    parameter int WIDTH  = 256,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [1:0]        reg_sel,
    input  logic [ADDR_W-1:0] addr,
    input  logic [7:0]        data_i,
    output logic [7:0]        data_o,
    input  logic              start,
    output logic              busy,
    output logic              done
`ifdef MODEXP_ERR_EN
    ,
    output logic              err
`endif
);

    localparam int NB = WIDTH / 8;
    localparam int CW = $clog2(2 * WIDTH + 1);
    localparam int IW = $clog2(WIDTH);
    localparam logic [ADDR_W:0] NBYTES = (ADDR_W + 1)'(NB);

    typedef enum logic [1:0] {IDLE, PRECOMP, MA_RUN, MA_FIX} state_t;
    typedef enum logic [1:0] {PH_MONT, PH_SQR, PH_MUL, PH_FIN} phase_t;

    state_t state;
    phase_t phase;

    logic [WIDTH-1:0] m_reg, e_reg, n_reg, result;
    logic [WIDTH-1:0] mw, ew, nw;
    logic [WIDTH-1:0] acc, x_reg, c_reg;
    logic [WIDTH-1:0] ma_a, ma_b;
    logic [WIDTH+1:0] t_reg;
    logic [CW-1:0]    cnt;
    logic [IW-1:0]    idx;

    logic [WIDTH:0]   c_dbl, c_nxt;
    logic [WIDTH+2:0] s_sum, u_sum;
    logic [WIDTH+1:0] t_step, t_fix;
    logic [WIDTH-1:0] ma_res, rd_word;
    logic             start_ok;

    // Doubling step of the R and R^2 precompute
    always_comb begin
        c_dbl = {c_reg, 1'b0};
        c_nxt = c_dbl;
        if (c_dbl >= {1'b0, nw}) c_nxt = c_dbl - {1'b0, nw};
    end

    // One bit-serial Montgomery step plus the final conditional subtract
    always_comb begin
        s_sum = {1'b0, t_reg};
        if (ma_a[0]) s_sum = s_sum + {3'b000, ma_b};
        u_sum = s_sum;
        if (s_sum[0]) u_sum = s_sum + {3'b000, nw};
        t_step = (WIDTH + 2)'(u_sum >> 1);
        t_fix = t_reg;
        if (t_reg >= {2'b00, nw}) t_fix = t_reg - {2'b00, nw};
        ma_res = WIDTH'(t_fix);
    end

    always_comb begin
        rd_word = result;
        case (reg_sel)
            2'd1:    rd_word = m_reg;
            2'd2:    rd_word = e_reg;
            2'd3:    rd_word = n_reg;
            default: rd_word = result;
        endcase
    end

`ifdef MODEXP_ERR_EN
    logic n_bad;
    assign n_bad    = ~n_reg[0] | (n_reg == WIDTH'(1));
    assign start_ok = start & ~n_bad;
`else
    assign start_ok = start;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_reg  <= '0;
            e_reg  <= '0;
            n_reg  <= '0;
            data_o <= '0;
        end else begin
            if (we && !busy) begin
                for (int k = 0; k < NB; k++) begin
                    if (addr == ADDR_W'(k)) begin
                        case (reg_sel)
                            2'd1:    m_reg[k*8 +: 8] <= data_i;
                            2'd2:    e_reg[k*8 +: 8] <= data_i;
                            2'd3:    n_reg[k*8 +: 8] <= data_i;
                            default: ;
                        endcase
                    end
                end
            end
            if ({1'b0, addr} < NBYTES)
                data_o <= 8'(rd_word >> {addr, 3'b000});
            else
                data_o <= 8'h00;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            phase  <= PH_MONT;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            mw     <= '0;
            ew     <= '0;
            nw     <= '0;
            acc    <= '0;
            x_reg  <= '0;
            c_reg  <= '0;
            ma_a   <= '0;
            ma_b   <= '0;
            t_reg  <= '0;
            cnt    <= '0;
            idx    <= '0;
`ifdef MODEXP_ERR_EN
            err    <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_ok) begin
                        mw    <= m_reg;
                        ew    <= e_reg;
                        nw    <= n_reg;
                        c_reg <= WIDTH'(1);
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= PRECOMP;
                    end
`ifdef MODEXP_ERR_EN
                    if (start) begin
                        err <= n_bad;
                        if (n_bad) begin
                            result <= '0;
                            done   <= 1'b1;
                        end
                    end
`endif
                end
                PRECOMP: begin
                    c_reg <= WIDTH'(c_nxt);
                    cnt   <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) acc <= WIDTH'(c_nxt);
                    if (cnt == CW'(2 * WIDTH - 1)) begin
                        ma_a  <= mw;
                        ma_b  <= WIDTH'(c_nxt);
                        t_reg <= '0;
                        cnt   <= '0;
                        phase <= PH_MONT;
                        state <= MA_RUN;
                    end
                end
                MA_RUN: begin
                    t_reg <= t_step;
                    ma_a  <= ma_a >> 1;
                    cnt   <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) state <= MA_FIX;
                end
                MA_FIX: begin
                    t_reg <= '0;
                    cnt   <= '0;
                    state <= MA_RUN;
                    case (phase)
                        PH_MONT: begin
                            x_reg <= ma_res;
                            ma_a  <= acc;
                            ma_b  <= acc;
                            idx   <= IW'(WIDTH - 1);
                            phase <= PH_SQR;
                        end
                        PH_SQR: begin
                            acc  <= ma_res;
                            ma_a <= ma_res;
                            if (ew[idx]) begin
                                ma_b  <= x_reg;
                                phase <= PH_MUL;
                            end else if (idx == '0) begin
                                ma_b  <= WIDTH'(1);
                                phase <= PH_FIN;
                            end else begin
                                ma_b  <= ma_res;
                                idx   <= idx - 1'b1;
                                phase <= PH_SQR;
                            end
                        end
                        PH_MUL: begin
                            acc  <= ma_res;
                            ma_a <= ma_res;
                            if (idx == '0) begin
                                ma_b  <= WIDTH'(1);
                                phase <= PH_FIN;
                            end else begin
                                ma_b  <= ma_res;
                                idx   <= idx - 1'b1;
                                phase <= PH_SQR;
                            end
                        end
                        default: begin
                            result <= ma_res;
                            done   <= 1'b1;
                            busy   <= 1'b0;
                            state  <= IDLE;
                        end
                    endcase
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mod_exp_core.sv
// Randomised self-checking bench for mod_exp_core at WIDTH=16.
// Expected results come from repeated modular multiplication.
module tb_mod_exp_core;

    localparam int W  = 16;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          we = 1'b0;
    logic [1:0]    reg_sel = 2'd0;
    logic [AW-1:0] addr = '0;
    logic [7:0]    data_i = 8'h00;
    logic [7:0]    data_o;
    logic          start = 1'b0;
    logic          busy;
    logic          done;
`ifdef MODEXP_ERR_EN
    logic          err;
`endif

    int n_cmp = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    mod_exp_core #(.WIDTH(W), .ADDR_W(AW)) dut (
        .clk(clk),
        .reset(reset),
        .we(we),
        .reg_sel(reg_sel),
        .addr(addr),
        .data_i(data_i),
        .data_o(data_o),
        .start(start),
        .busy(busy),
        .done(done)
`ifdef MODEXP_ERR_EN
        ,
        .err(err)
`endif
    );

    function automatic longint ref_exp(longint m, longint e, longint n);
        longint r;
        r = 1 % n;
        for (longint k = 0; k < e; k++) r = (r * m) % n;
        return r;
    endfunction

    function automatic int ref_lat(logic [W-1:0] e);
        return 2 * W + (W + 1) * (2 + W + $countones(e));
    endfunction

    task automatic wr(input logic [1:0] s, input logic [AW-1:0] a, input logic [7:0] d);
        we = 1'b1; reg_sel = s; addr = a; data_i = d;
        @(negedge clk);
        we = 1'b0;
    endtask

    task automatic rd(input logic [1:0] s, input logic [AW-1:0] a, output logic [7:0] d);
        reg_sel = s; addr = a;
        @(negedge clk);
        d = data_o;
    endtask

    task automatic load(input logic [15:0] m, input logic [15:0] e, input logic [15:0] n);
        wr(2'd1, 0, m[7:0]); wr(2'd1, 1, m[15:8]);
        wr(2'd2, 0, e[7:0]); wr(2'd2, 1, e[15:8]);
        wr(2'd3, 0, n[7:0]); wr(2'd3, 1, n[15:8]);
    endtask

    task automatic wait_done(inout int cyc);
        while (done !== 1'b1 && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic read_result(output logic [15:0] res);
        logic [7:0] lo, hi;
        rd(2'd0, 0, lo);
        rd(2'd0, 1, hi);
        res = {hi, lo};
    endtask

    task automatic do_run(output int cyc, output logic [15:0] res);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        wait_done(cyc);
        read_result(res);
    endtask

    task automatic test_reset;
        logic [7:0] d;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (data_o !== 8'h00) begin n_mis++; $display("FAIL reset_data_o got %h want 00", data_o); end
        n_cmp++;
        if (busy !== 1'b0) begin n_mis++; $display("FAIL reset_busy got %b want 0", busy); end
        n_cmp++;
        if (done !== 1'b0) begin n_mis++; $display("FAIL reset_done got %b want 0", done); end
        reset = 1'b1;
        @(negedge clk);
        for (int s = 0; s < 4; s++) begin
            rd(s[1:0], 0, d);
            n_cmp++;
            if (d !== 8'h00) begin n_mis++; $display("FAIL reset_reg%0d got %h want 00", s, d); end
        end
    endtask

    task automatic test_directed;
        int cyc;
        logic [15:0] res;
        load(16'd3, 16'd4, 16'd7);
        do_run(cyc, res);
        n_cmp++;
        if (cyc != 355) begin n_mis++; $display("FAIL lat_3_4_7 got %0d want 355", cyc); end
        n_cmp++;
        if (res !== 16'h0004) begin n_mis++; $display("FAIL res_3_4_7 got %h want 0004", res); end
        load(16'd2, 16'd16, 16'hFFF1);
        do_run(cyc, res);
        n_cmp++;
        if (res[7:0] !== 8'h0F) begin n_mis++; $display("FAIL res_fermat_lo got %h want 0f", res[7:0]); end
        n_cmp++;
        if (res[15:8] !== 8'h00) begin n_mis++; $display("FAIL res_fermat_hi got %h want 00", res[15:8]); end
        load(16'd5, 16'd0, 16'd7);
        do_run(cyc, res);
        n_cmp++;
        if (res !== 16'h0001) begin n_mis++; $display("FAIL res_e0 got %h want 0001", res); end
        n_cmp++;
        if (cyc != ref_lat(16'd0)) begin n_mis++; $display("FAIL lat_e0 got %0d want %0d", cyc, ref_lat(16'd0)); end
        load(16'd0, 16'd3, 16'd7);
        do_run(cyc, res);
        n_cmp++;
        if (res !== 16'h0000) begin n_mis++; $display("FAIL res_m0 got %h want 0000", res); end
    endtask

    task automatic test_random;
        int cyc;
        logic [15:0] res, m, e, n, exp_r;
        for (int it = 0; it < 8; it++) begin
            n = 16'($urandom_range(65535, 3)) | 16'h0001;
            m = 16'($urandom % n);
            e = 16'($urandom);
            exp_r = 16'(ref_exp(longint'(m), longint'(e), longint'(n)));
            load(m, e, n);
            do_run(cyc, res);
            n_cmp++;
            if (res !== exp_r) begin
                n_mis++;
                $display("FAIL rand_res m=%h e=%h n=%h got %h want %h", m, e, n, res, exp_r);
            end
            n_cmp++;
            if (cyc != ref_lat(e)) begin
                n_mis++;
                $display("FAIL rand_lat e=%h got %0d want %0d", e, cyc, ref_lat(e));
            end
        end
    endtask

    task automatic test_busy_ignored;
        int cyc;
        logic [15:0] res;
        logic [7:0] d0, d1;
        load(16'd3, 16'd4, 16'd7);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        n_cmp++;
        if (busy !== 1'b1) begin n_mis++; $display("FAIL busy_high got %b want 1", busy); end
        repeat (20) begin @(negedge clk); cyc++; end
        we = 1'b1; reg_sel = 2'd1; addr = 0; data_i = 8'h34; start = 1'b1;
        @(negedge clk); cyc++;
        addr = 1; data_i = 8'h12; start = 1'b0;
        @(negedge clk); cyc++;
        we = 1'b0;
        wait_done(cyc);
        n_cmp++;
        if (cyc != 355) begin n_mis++; $display("FAIL busy_lat got %0d want 355", cyc); end
        read_result(res);
        n_cmp++;
        if (res !== 16'h0004) begin n_mis++; $display("FAIL busy_res got %h want 0004", res); end
        rd(2'd1, 0, d0);
        rd(2'd1, 1, d1);
        n_cmp++;
        if ({d1, d0} !== 16'h0003) begin n_mis++; $display("FAIL busy_m_hold got %h want 0003", {d1, d0}); end
    endtask

    task automatic test_write_with_start;
        int cyc;
        logic [15:0] res;
        logic [7:0] d;
        load(16'd3, 16'd4, 16'd7);
        we = 1'b1; reg_sel = 2'd1; addr = 0; data_i = 8'h05; start = 1'b1;
        @(negedge clk);
        we = 1'b0; start = 1'b0;
        cyc = 0;
        wait_done(cyc);
        read_result(res);
        n_cmp++;
        if (res !== 16'h0004) begin n_mis++; $display("FAIL ws_res got %h want 0004", res); end
        rd(2'd1, 0, d);
        n_cmp++;
        if (d !== 8'h05) begin n_mis++; $display("FAIL ws_m_landed got %h want 05", d); end
    endtask

    task automatic test_range_and_hold;
        logic [7:0] d;
        wr(2'd1, 2, 8'hAA);
        rd(2'd1, 2, d);
        n_cmp++;
        if (d !== 8'h00) begin n_mis++; $display("FAIL oor_read got %h want 00", d); end
        wr(2'd0, 0, 8'h55);
        repeat (10) @(negedge clk);
        rd(2'd0, 0, d);
        n_cmp++;
        if (d !== 8'h04) begin n_mis++; $display("FAIL result_hold got %h want 04", d); end
    endtask

    task automatic test_reset_mid;
        int cyc;
        logic [15:0] res;
        logic [7:0] d;
        load(16'd3, 16'd4, 16'd7);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        reset = 1'b0;
        #1;
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_mis++;
            $display("FAIL midreset_async busy=%b done=%b want 0 0", busy, done);
        end
        @(negedge clk);
        reset = 1'b1;
        rd(2'd0, 0, d);
        n_cmp++;
        if (d !== 8'h00) begin n_mis++; $display("FAIL midreset_result got %h want 00", d); end
        repeat (5) @(negedge clk);
        n_cmp++;
        if (done !== 1'b0) begin n_mis++; $display("FAIL midreset_nodone got %b want 0", done); end
        load(16'd3, 16'd4, 16'd7);
        do_run(cyc, res);
        n_cmp++;
        if (res !== 16'h0004 || cyc != 355) begin
            n_mis++;
            $display("FAIL midreset_rerun res=%h cyc=%0d want 0004 355", res, cyc);
        end
    endtask

`ifdef MODEXP_ERR_EN
    task automatic test_err;
        int cyc;
        logic [15:0] res;
        load(16'd3, 16'd4, 16'd8);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_cmp++;
        if (done !== 1'b1 || busy !== 1'b0 || err !== 1'b1) begin
            n_mis++;
            $display("FAIL err_reject done=%b busy=%b err=%b want 1 0 1", done, busy, err);
        end
        read_result(res);
        n_cmp++;
        if (res !== 16'h0000) begin n_mis++; $display("FAIL err_result got %h want 0000", res); end
        load(16'd3, 16'd4, 16'd7);
        do_run(cyc, res);
        n_cmp++;
        if (err !== 1'b0 || res !== 16'h0004) begin
            n_mis++;
            $display("FAIL err_clear err=%b res=%h want 0 0004", err, res);
        end
    endtask
`endif

    initial begin
        #3_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_busy_ignored();
        test_write_with_start();
        test_range_and_hold();
        test_reset_mid();
`ifdef MODEXP_ERR_EN
        test_err();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
